// File: rtl/picomem_timer.sv
// rtl/picomem_timer.sv - PicoMem 32-bit down-counting timer slave (optional capture: PICOMEM_TIMER_CAPTURE_EN)
module picomem_timer #(
  parameter logic [31:0] RESET_RELOAD = 32'hFFFF_FFFF,
  parameter int          PRE_W        = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        busin_valid,
  input  logic [31:0] busin_addr,
  input  logic [31:0] busin_wdata,
  input  logic [3:0]  busin_wstrb,
  output logic        busin_ready,
  output logic [31:0] busin_rdata,
  output logic        irq
`ifdef PICOMEM_TIMER_CAPTURE_EN
  ,
  input  logic        capt_in
`endif
);

  localparam logic [31:0] BAD_READ = 32'hDEAD_BEEF;

  logic             ctrl_en;
  logic             ctrl_auto;
  logic             ctrl_ie;
  logic [PRE_W-1:0] ctrl_pre;
  logic [31:0]      count;
  logic [31:0]      reload;
  logic             pend;
  logic [PRE_W-1:0] pcnt;

  logic             acc;
  logic             wr_en;
  logic [2:0]       idx;
  logic [31:0]      wmask;
  logic             ctrl_wr;
  logic             count_wr;
  logic             reload_wr;
  logic             status_wr;
  logic             tick;
  logic             timeout;
  logic [PRE_W-1:0] pre_new;
  logic [31:0]      ctrl_img;
  logic [31:0]      rd_mux;
  logic             unused_addr;

  // Only addr[4:2] selects a register; the rest of the address is ignored.
  assign unused_addr = ^{busin_addr[31:5], busin_addr[1:0]};

  assign acc       = busin_valid && !busin_ready;
  assign wr_en     = acc && (busin_wstrb != 4'b0000);
  assign idx       = busin_addr[4:2];
  assign wmask     = {{8{busin_wstrb[3]}}, {8{busin_wstrb[2]}},
                      {8{busin_wstrb[1]}}, {8{busin_wstrb[0]}}};
  assign ctrl_wr   = wr_en && (idx == 3'd0);
  assign count_wr  = wr_en && (idx == 3'd1);
  assign reload_wr = wr_en && (idx == 3'd2);
  assign status_wr = wr_en && (idx == 3'd3);

  assign tick    = ctrl_en && (pcnt == ctrl_pre);
  assign timeout = tick && (count == 32'd0);
  assign irq     = pend && ctrl_ie;

  // Byte-merge the prescaler field; each PRE bit lives in the byte lane (8+i)/8.
  always_comb begin
    pre_new = ctrl_pre;
    for (int i = 0; i < PRE_W; i++) begin
      if (busin_wstrb[(8 + i) / 8]) pre_new[i] = busin_wdata[8 + i];
    end
  end

  // CTRL as seen on the bus; unimplemented bits read 0.
  always_comb begin
    ctrl_img             = 32'd0;
    ctrl_img[0]          = ctrl_en;
    ctrl_img[1]          = ctrl_auto;
    ctrl_img[2]          = ctrl_ie;
    ctrl_img[8 +: PRE_W] = ctrl_pre;
  end

`ifdef PICOMEM_TIMER_CAPTURE_EN
  logic        capt_s1;
  logic        capt_s2;
  logic        capt_s3;
  logic [31:0] capt;

  // Synchronise capt_in and latch COUNT on each synchronised rising edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      capt_s1 <= 1'b0;
      capt_s2 <= 1'b0;
      capt_s3 <= 1'b0;
      capt    <= 32'd0;
    end else begin
      capt_s1 <= capt_in;
      capt_s2 <= capt_s1;
      capt_s3 <= capt_s2;
      if (capt_s2 && !capt_s3) capt <= count;
    end
  end
`endif

  // Read mux; unmapped indices return a recognisable poison value.
  always_comb begin
    rd_mux = BAD_READ;
    case (idx)
      3'd0: rd_mux = ctrl_img;
      3'd1: rd_mux = count;
      3'd2: rd_mux = reload;
      3'd3: rd_mux = {31'd0, pend};
`ifdef PICOMEM_TIMER_CAPTURE_EN
      3'd4: rd_mux = capt;
`endif
      default: rd_mux = BAD_READ;
    endcase
  end

  // Single-pulse ready handshake; rdata captures the pre-write value and holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busin_ready <= 1'b0;
      busin_rdata <= 32'd0;
    end else begin
      busin_ready <= acc;
      if (acc) busin_rdata <= rd_mux;
    end
  end

  // CTRL fields; a one-shot timeout clears EN unless the bus writes CTRL that cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      ctrl_pre  <= '0;
    end else if (ctrl_wr) begin
      if (busin_wstrb[0]) begin
        ctrl_en   <= busin_wdata[0];
        ctrl_auto <= busin_wdata[1];
        ctrl_ie   <= busin_wdata[2];
      end
      ctrl_pre <= pre_new;
    end else if (timeout && !ctrl_auto) begin
      ctrl_en <= 1'b0;
    end
  end

  // Prescaler: counts 0..PRE while enabled, restarts on any CTRL write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcnt <= '0;
    end else if (!ctrl_en || ctrl_wr || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // COUNT: bus write wins over the tick-driven decrement or reload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= RESET_RELOAD;
    end else if (count_wr) begin
      count <= (count & ~wmask) | (busin_wdata & wmask);
    end else if (tick) begin
      if (count != 32'd0) count <= count - 32'd1;
      else if (ctrl_auto) count <= reload;
    end
  end

  // RELOAD: plain byte-writable register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reload <= RESET_RELOAD;
    end else if (reload_wr) begin
      reload <= (reload & ~wmask) | (busin_wdata & wmask);
    end
  end

  // PEND: hardware set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= 1'b0;
    end else if (timeout) begin
      pend <= 1'b1;
    end else if (status_wr && busin_wstrb[0] && busin_wdata[0]) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_picomem_timer.sv
// tb/tb_picomem_timer.sv - scoreboard bench for picomem_timer (capture checks with PICOMEM_TIMER_CAPTURE_EN)
module tb_picomem_timer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        busin_valid;
  logic [31:0] busin_addr;
  logic [31:0] busin_wdata;
  logic [3:0]  busin_wstrb;
  logic        busin_ready;
  logic [31:0] busin_rdata;
  logic        irq;
`ifdef PICOMEM_TIMER_CAPTURE_EN
  logic        capt_in;
`endif

  always #5 clk = ~clk;

  picomem_timer dut (
    .clk         (clk),
    .resetn      (resetn),
    .busin_valid (busin_valid),
    .busin_addr  (busin_addr),
    .busin_wdata (busin_wdata),
    .busin_wstrb (busin_wstrb),
    .busin_ready (busin_ready),
    .busin_rdata (busin_rdata),
    .irq         (irq)
`ifdef PICOMEM_TIMER_CAPTURE_EN
    ,
    .capt_in     (capt_in)
`endif
  );

  typedef struct {
    logic [31:0] exp;
    logic        chk;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (resetn === 1'b1 && busin_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 expected no access pending");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.chk) check(e.name, busin_rdata, e.exp);
      end
    end
  end

  task automatic bus(input logic [2:0] idx, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] exp, input logic chk, input string name);
    exp_t e;
    int   n;
    e.exp = exp; e.chk = chk; e.name = name;
    sbq.push_back(e);
    busin_addr  = {27'd0, idx, 2'b00};
    busin_wdata = wd;
    busin_wstrb = ws;
    busin_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busin_ready !== 1'b1 && n < 8);
    check({name, " latency"}, n, 1);
    busin_valid = 1'b0;
    busin_wstrb = 4'h0;
    last_acc    = cyc;
    @(negedge clk);
    check({name, " pulse"}, {31'd0, busin_ready}, 0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] wd, input string name);
    bus(idx, wd, 4'hF, 32'd0, 1'b0, name);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
    bus(idx, 32'd0, 4'h0, exp, 1'b1, name);
  endtask

  task automatic wait_irq(output int at);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int pw;
    int pc;
    int t1;
    int t2;
    resetn      = 1'b0;
    busin_valid = 1'b0;
    busin_addr  = 32'd0;
    busin_wdata = 32'd0;
    busin_wstrb = 4'h0;
`ifdef PICOMEM_TIMER_CAPTURE_EN
    capt_in     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, busin_ready}, 0);
    check("reset rdata", busin_rdata, 0);
    check("reset irq", {31'd0, irq}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Reset register values
    rd(3'd0, 32'h0000_0000, "reset CTRL");
    rd(3'd1, 32'hFFFF_FFFF, "reset COUNT");
    rd(3'd2, 32'hFFFF_FFFF, "reset RELOAD");
    rd(3'd3, 32'h0000_0000, "reset STATUS");
`ifdef PICOMEM_TIMER_CAPTURE_EN
    rd(3'd4, 32'h0000_0000, "reset CAPT");
`else
    rd(3'd4, 32'hDEAD_BEEF, "reset idx4");
`endif

    // Periodic: timeouts every 10 clocks, W1C between them, then a W1C colliding with a timeout
    wr(3'd2, 32'd9, "periodic RELOAD");
    wr(3'd1, 32'd9, "periodic COUNT");
    wr(3'd0, 32'h0000_0007, "periodic CTRL");
    pw = last_acc;
    wait_irq(t1);
    check("periodic first timeout", t1 - pw, 10);
    wr(3'd3, 32'd1, "periodic W1C");
    check("periodic irq cleared", {31'd0, irq}, 0);
    wait_irq(t2);
    check("periodic second timeout", t2 - t1, 10);
    wr(3'd3, 32'd1, "collision pre-clear");
    wait_cyc(pw + 29);
    bus(3'd3, 32'd1, 4'hF, 32'd0, 1'b1, "collision W1C rdata");
    check("collision aligned", last_acc - pw, 30);
    rd(3'd3, 32'd1, "collision PEND kept");

    // COUNT write on a tick cycle (PRE=3: ticks at pc+4k)
    wr(3'd0, 32'h0000_0303, "ctrl pre3 auto");
    pc = last_acc;
    wait_cyc(pc + 7);
    wr(3'd1, 32'h0000_0100, "COUNT on tick");
    check("count write aligned", last_acc - pc, 8);
    rd(3'd1, 32'h0000_0100, "COUNT write wins");

    // Byte write to CTRL and unmapped read
    bus(3'd0, 32'h0000_0700, 4'b0010, 32'h0000_0303, 1'b1, "CTRL byte write rdata");
    rd(3'd0, 32'h0000_0703, "CTRL after byte write");
    rd(3'd7, 32'hDEAD_BEEF, "idx7 read");

    // One-shot: COUNT=4, PRE=3 -> irq after 20 clocks, EN drops, COUNT stays 0
    wr(3'd0, 32'h0000_0000, "stop");
    wr(3'd3, 32'd1, "clear pend");
    check("irq idle", {31'd0, irq}, 0);
    wr(3'd1, 32'd4, "oneshot COUNT");
    wr(3'd0, 32'h0000_0305, "oneshot CTRL");
    pw = last_acc;
    wait_irq(t1);
    check("oneshot timeout", t1 - pw, 20);
    rd(3'd0, 32'h0000_0304, "oneshot EN cleared");
    rd(3'd1, 32'h0000_0000, "oneshot COUNT zero");
    rd(3'd3, 32'h0000_0001, "oneshot PEND");

`ifdef PICOMEM_TIMER_CAPTURE_EN
    // Capture: COUNT after pc+k is 1000-k; edge at pc+5.5 latches COUNT at pc+8 (value after pc+7)
    wr(3'd0, 32'h0000_0000, "capt stop");
    wr(3'd1, 32'd1000, "capt COUNT");
    wr(3'd0, 32'h0000_0001, "capt CTRL");
    pc = last_acc;
    wait_cyc(pc + 5);
    capt_in = 1'b1;
    repeat (4) @(negedge clk);
    capt_in = 1'b0;
    rd(3'd4, 32'd993, "CAPT value");
`endif

    // Reset in the middle of an access
    busin_addr  = 32'h0000_0004;
    busin_wstrb = 4'h0;
    busin_valid = 1'b1;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset ready", {31'd0, busin_ready}, 0);
    check("midreset irq", {31'd0, irq}, 0);
    check("midreset rdata", busin_rdata, 0);
    busin_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rd(3'd0, 32'h0000_0000, "post-reset CTRL");
    rd(3'd1, 32'hFFFF_FFFF, "post-reset COUNT");
    rd(3'd2, 32'hFFFF_FFFF, "post-reset RELOAD");
    rd(3'd3, 32'h0000_0000, "post-reset STATUS");

    repeat (2) @(negedge clk);
    check("scoreboard drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
